// File: rtl/da_pkg.sv
// da_pkg: shared FSM state type and sizing helpers for the DA column MAC
package da_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int KERNEL_H_FIXED = 7;
  function automatic int acc_min_w(input int lut_w, input int pix_w);
    return lut_w + pix_w;
  endfunction
endpackage

// File: rtl/lut_mul.sv
// lut_mul: signed weighted sum of one bit-plane across the column taps
module lut_mul #(
  parameter int KERNEL_H = 7,
  parameter int DATA_W = 8,
  parameter logic signed [4:0] WEIGHT_0 = 5'sd1,
  parameter logic signed [4:0] WEIGHT_1 = -5'sd2,
  parameter logic signed [4:0] WEIGHT_2 = 5'sd3,
  parameter logic signed [4:0] WEIGHT_3 = -5'sd4,
  parameter logic signed [4:0] WEIGHT_4 = 5'sd5,
  parameter logic signed [4:0] WEIGHT_5 = -5'sd6,
  parameter logic signed [4:0] WEIGHT_6 = 5'sd7
) (
  input  logic [7:0]               sel,
  output logic signed [DATA_W-1:0] sum
);
  // the padding bit carries a zero weight so the 8-bit index stays uniform
  localparam logic signed [4:0] W [8] = '{WEIGHT_0, WEIGHT_1, WEIGHT_2, WEIGHT_3,
                                          WEIGHT_4, WEIGHT_5, WEIGHT_6, 5'sd0};
  if (KERNEL_H > 7) begin : g_kh_chk
    $error("lut_mul supports at most 7 taps");
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < 8; k++) sum = sel[k] ? sum + DATA_W'(W[k]) : sum;
  end
endmodule

// File: rtl/da_column_mac.sv
// da_column_mac: bit-serial distributed-arithmetic MAC for one kernel column,
// one bit-plane per cycle, MSB first, shift-accumulated into the dot product
module da_column_mac
  import da_pkg::*;
#(
  parameter int KERNEL_H = 7,
  parameter int PIX_W = 8,
  parameter int PIX_SIGNED = 0,
  parameter int LUT_W = 8,
  parameter int ACC_W = 16,
  parameter logic signed [4:0] WEIGHT_0 = 5'sd1,
  parameter logic signed [4:0] WEIGHT_1 = -5'sd2,
  parameter logic signed [4:0] WEIGHT_2 = 5'sd3,
  parameter logic signed [4:0] WEIGHT_3 = -5'sd4,
  parameter logic signed [4:0] WEIGHT_4 = 5'sd5,
  parameter logic signed [4:0] WEIGHT_5 = -5'sd6,
  parameter logic signed [4:0] WEIGHT_6 = 5'sd7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [KERNEL_H*PIX_W-1:0] in_col,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACC_W-1:0]   out_data
);
  localparam int CW = PIX_W > 1 ? $clog2(PIX_W) : 1;
  if (ACC_W < acc_min_w(LUT_W, PIX_W)) begin : g_acc_chk
    $error("ACC_W narrower than LUT_W+PIX_W");
  end
  if (KERNEL_H != KERNEL_H_FIXED) begin : g_kh_chk
    $error("KERNEL_H must be 7");
  end
  state_t state, state_nx;
  logic [CW-1:0] bit_cnt;
  logic [KERNEL_H*PIX_W-1:0] pix_sr;
  logic [7:0] d;
  logic signed [LUT_W-1:0] sum;
  logic signed [ACC_W-1:0] acc, s, acc_nx;
  logic accept, first;
  always_comb begin
    d = '0;
    for (int k = 0; k < KERNEL_H; k++) d[k] = pix_sr[k*PIX_W + int'(bit_cnt)];
  end
  lut_mul #(
    .KERNEL_H(KERNEL_H), .DATA_W(LUT_W),
    .WEIGHT_0(WEIGHT_0), .WEIGHT_1(WEIGHT_1), .WEIGHT_2(WEIGHT_2), .WEIGHT_3(WEIGHT_3),
    .WEIGHT_4(WEIGHT_4), .WEIGHT_5(WEIGHT_5), .WEIGHT_6(WEIGHT_6)
  ) u_lut (
    .sel(d),
    .sum(sum)
  );
  // the MSB plane carries negative weight for two's-complement pixels
  assign s = ACC_W'(sum);
  assign first = bit_cnt == CW'(PIX_W - 1);
  assign acc_nx = first ? (PIX_SIGNED != 0 ? -s : s) : (acc <<< 1) + s;
  always_comb begin
    in_ready = state == IDLE || (state == DONE && out_ready);
    out_valid = state == DONE;
    accept = in_valid && in_ready && !clear;
    state_nx = clear ? IDLE
             : accept ? BUSY
             : (state == BUSY && bit_cnt == '0) ? DONE
             : (state == DONE && out_ready) ? IDLE
             : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      bit_cnt <= '0;
      pix_sr <= '0;
      out_data <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (accept) begin
      pix_sr <= in_col;
      bit_cnt <= CW'(PIX_W - 1);
    end else if (state == BUSY) begin
      acc <= acc_nx;
      bit_cnt <= bit_cnt - 1'b1;
      if (bit_cnt == '0) out_data <= acc_nx;
    end
endmodule
